// File: rtl/scandoubler_pkg.sv
// Shared types and helpers for the scandoubler control blocks.
package scandoubler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_MUTE    = 2'd2
    } sd_state_t;

    localparam int MUTE_CW = 4;

    // Bits needed to hold the values 0..value-1.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/scandoubler_ce_gen.sv
// Free-running pixel clock-enable generator: oce every ODIV clocks, ice every 2*ODIV,
// both registered and coincident on ice cycles.
module scandoubler_ce_gen
    import scandoubler_pkg::*;
#(
    parameter int ODIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_ice,
    output logic o_oce
);

    localparam int             CW   = clog2(2 * ODIV);
    localparam logic [CW-1:0]  LAST = CW'(2 * ODIV - 1);
    localparam logic [CW-1:0]  HALF = CW'(ODIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            o_ice <= 1'b0;
            o_oce <= 1'b0;
        end else begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            o_ice <= (r_cnt == LAST);
            o_oce <= (r_cnt == HALF) || (r_cnt == LAST);
        end
    end

endmodule

// File: rtl/scandoubler_ctl.sv
// Scandoubler controller: clock enables plus frame-aligned, muted 15/31 kHz mode switching.
// Optional scanline toggle is built when SCANDOUBLER_CTL_SCANLINES_EN is defined.
module scandoubler_ctl
    import scandoubler_pkg::*;
#(
    parameter int   ODIV        = 4,
    parameter int   MUTE_FRAMES = 2,
    parameter logic INIT_EN     = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic req,
    input  logic vsync,
    output logic ice,
    output logic oce,
    output logic enable,
    output logic mute,
    output logic busy,
    output logic done,
    input  logic sl_req,
    output logic scanlines
);

    logic                w_ice;
    logic                w_oce;
    logic                w_vs_rise;
    logic                w_switch;
    logic                w_finish;
    logic                w_mute;
    logic                w_busy;
    sd_state_t           r_state;
    sd_state_t           w_next_state;
    logic                r_vs_hist;
    logic                r_enable;
    logic                r_pending;
    logic                r_done;
    logic [MUTE_CW-1:0]  r_frames;

    scandoubler_ce_gen #(.ODIV(ODIV)) u_ce_gen (
        .i_clk   (clock),
        .i_rst_n (reset),
        .o_ice   (w_ice),
        .o_oce   (w_oce)
    );

    // vsync is only looked at on ice cycles, so sub-pixel glitches never register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vs_hist <= 1'b0;
        end else if (w_ice) begin
            r_vs_hist <= vsync;
        end
    end

    assign w_vs_rise = w_ice && vsync && !r_vs_hist;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (req || r_pending) w_next_state = ST_WAIT_VS;
            ST_WAIT_VS: if (w_vs_rise) w_next_state = (MUTE_FRAMES == 0) ? ST_IDLE : ST_MUTE;
            ST_MUTE:    if (w_vs_rise && (r_frames == MUTE_CW'(1))) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_mute = 1'b0;
        w_busy = 1'b0;
        if (r_state != ST_IDLE) begin
            w_mute = 1'b1;
            w_busy = 1'b1;
        end
    end

    assign w_switch = (r_state == ST_WAIT_VS) && w_vs_rise;
    assign w_finish = (r_state != ST_IDLE) && (w_next_state == ST_IDLE);

    // A request arriving while busy is remembered once and replayed from IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_enable  <= INIT_EN;
            r_frames  <= '0;
            r_pending <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_switch) begin
                r_enable <= ~r_enable;
                r_frames <= MUTE_CW'(MUTE_FRAMES);
            end else if ((r_state == ST_MUTE) && w_vs_rise) begin
                r_frames <= r_frames - 1'b1;
            end
            if (r_state == ST_IDLE) begin
                r_pending <= 1'b0;
            end else if (req) begin
                r_pending <= 1'b1;
            end
        end
    end

`ifdef SCANDOUBLER_CTL_SCANLINES_EN
    logic r_sl_pending;
    logic r_scanlines;

    // Dropping to 15 kHz kills scanlines on the switch edge itself.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sl_pending <= 1'b0;
            r_scanlines  <= 1'b0;
        end else begin
            if (w_switch && r_enable) begin
                r_scanlines <= 1'b0;
            end else if (w_vs_rise && r_sl_pending) begin
                r_scanlines <= ~r_scanlines;
            end
            if (w_vs_rise && r_sl_pending) begin
                r_sl_pending <= 1'b0;
            end else if (sl_req) begin
                r_sl_pending <= 1'b1;
            end
        end
    end

    assign scanlines = r_scanlines;
`else
    logic w_unused_sl;
    assign w_unused_sl = sl_req;
    assign scanlines   = 1'b0;
`endif

    assign ice    = w_ice;
    assign oce    = w_oce;
    assign enable = r_enable;
    assign mute   = w_mute;
    assign busy   = w_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_scandoubler_ctl.sv
// Directed bench for scandoubler_ctl (ODIV=4, MUTE_FRAMES=2, INIT_EN=1).
module tb_scandoubler_ctl;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic req    = 1'b0;
    logic vsync  = 1'b0;
    logic sl_req = 1'b0;
    logic ice, oce, enable, mute, busy, done, scanlines;

    int checks   = 0;
    int failures = 0;

`ifdef SCANDOUBLER_CTL_SCANLINES_EN
    localparam logic SL_ON = 1'b1;
`else
    localparam logic SL_ON = 1'b0;
`endif

    scandoubler_ctl #(.ODIV(4), .MUTE_FRAMES(2), .INIT_EN(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .vsync     (vsync),
        .ice       (ice),
        .oce       (oce),
        .enable    (enable),
        .mute      (mute),
        .busy      (busy),
        .done      (done),
        .sl_req    (sl_req),
        .scanlines (scanlines)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wait_ice();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!ice && n < 32);
        chk("wait_ice", ice, 1'b1);
    endtask

    // One ice cycle samples vsync low, the next sees it high: exactly one vs_rise.
    task automatic frame_rise(input logic with_req);
        wait_ice();
        wait_ice();
        vsync = 1'b1;
        req   = with_req;
        step();
        vsync = 1'b0;
        req   = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic e_en, input logic e_mute,
                           input logic e_busy, input logic e_done);
        chk({tag, "_enable"}, enable, e_en);
        chk({tag, "_mute"},   mute,   e_mute);
        chk({tag, "_busy"},   busy,   e_busy);
        chk({tag, "_done"},   done,   e_done);
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk_all("rst", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_ice", ice, 1'b0);
        chk("rst_oce", oce, 1'b0);
        chk("rst_scanlines", scanlines, 1'b0);

        // Divider cadence after release
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("oce_e%0d", k), oce, (k % 4 == 0));
            chk($sformatf("ice_e%0d", k), ice, (k % 8 == 0));
        end

        // Basic switch 1 -> 0 with two mute frames
        req = 1'b1;
        step();
        req = 1'b0;
        chk_all("a_req", 1'b1, 1'b1, 1'b1, 1'b0);
        frame_rise(1'b0);
        chk_all("a_vs1", 1'b0, 1'b1, 1'b1, 1'b0);
        frame_rise(1'b0);
        chk_all("a_vs2", 1'b0, 1'b1, 1'b1, 1'b0);
        frame_rise(1'b0);
        chk_all("a_vs3", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk_all("a_post", 1'b0, 1'b0, 1'b0, 1'b0);

        // Request coincident with vs_rise: that edge is not consumed
        wait_ice();
        wait_ice();
        vsync = 1'b1;
        req   = 1'b1;
        step();
        vsync = 1'b0;
        req   = 1'b0;
        chk_all("c_req", 1'b0, 1'b1, 1'b1, 1'b0);

        // 3-clock vsync glitch between ice cycles is invisible
        wait_ice();
        step();
        vsync = 1'b1;
        repeat (3) step();
        vsync = 1'b0;
        wait_ice();
        wait_ice();
        chk_all("c_glitch", 1'b0, 1'b1, 1'b1, 1'b0);
        frame_rise(1'b0);
        chk_all("c_vs1", 1'b1, 1'b1, 1'b1, 1'b0);
        frame_rise(1'b0);
        frame_rise(1'b0);
        chk_all("c_vs3", 1'b1, 1'b0, 1'b0, 1'b1);
        step();

        // Three requests in one sequence (last on the finishing edge) -> two toggles
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        req = 1'b1;
        step();
        req = 1'b0;
        chk_all("b_req", 1'b1, 1'b1, 1'b1, 1'b0);
        frame_rise(1'b0);
        chk_all("b_vs1", 1'b0, 1'b1, 1'b1, 1'b0);
        frame_rise(1'b0);
        frame_rise(1'b1);
        chk_all("b_done1", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk_all("b_restart", 1'b0, 1'b1, 1'b1, 1'b0);
        frame_rise(1'b0);
        chk_all("b_vs4", 1'b1, 1'b1, 1'b1, 1'b0);
        frame_rise(1'b0);
        frame_rise(1'b0);
        chk_all("b_done2", 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (20) step();
        chk_all("b_idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in MUTE, with a request pending
        req = 1'b1;
        step();
        req = 1'b0;
        frame_rise(1'b0);
        chk_all("e_mute", 1'b0, 1'b1, 1'b1, 1'b0);
        req = 1'b1;
        step();
        req = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk_all("e_async", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("e_ice", ice, 1'b0);
        chk("e_oce", oce, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) step();
        chk("e_oce_e3", oce, 1'b0);
        step();
        chk("e_oce_e4", oce, 1'b1);
        repeat (30) step();
        chk_all("e_nopend", 1'b1, 1'b0, 1'b0, 1'b0);

        // Scanline toggle, then forced off by a switch to enable=0
        sl_req = 1'b1;
        step();
        sl_req = 1'b0;
        frame_rise(1'b0);
        chk("f_sl_on", scanlines, SL_ON);
        chk_all("f_sl", 1'b1, 1'b0, 1'b0, 1'b0);
        req = 1'b1;
        step();
        req = 1'b0;
        chk("f_sl_hold", scanlines, SL_ON);
        frame_rise(1'b0);
        chk("f_sl_off", scanlines, 1'b0);
        chk_all("f_switch", 1'b0, 1'b1, 1'b1, 1'b0);
        frame_rise(1'b0);
        frame_rise(1'b0);
        chk_all("f_done", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
